// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared size encodings, sequencer states and byte-count helper.
package mem_seq_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    return size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits 32-bit byte/half/word loads and stores into
// single-byte cycles on a byte-wide RAM with combinational read.
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  output logic              ram_sel,
  input  logic [7:0]        ram_q
);

  function automatic logic [31:0] load_ext(input logic [31:0] v, input logic [1:0] sz, input logic sx);
    return sz == SZ_BYTE ? {{24{sx & v[7]}}, v[7:0]} :
           sz == SZ_HALF ? {{16{sx & v[15]}}, v[15:0]} : v;
  endfunction

  state_t            state;
  logic [1:0]        cnt, last, size_r;
  logic              we_r, sx_r, err_r, bad, ld_ok;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wd, asm_q, asm_nx, rdata_q;
  logic [2:0]        n_m1;

  assign bad = size == 2'd3 || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'd0);
  assign n_m1 = byte_count(size) - 3'd1;
  assign ld_ok = state == DONE && !we_r && !err_r;

  always_comb begin
    asm_nx = asm_q;
    asm_nx[{cnt, 3'b000} +: 8] = ram_q;
  end

  assign ready    = state == IDLE;
  assign done     = state == DONE;
  assign err      = done && err_r;
  assign rdata    = ld_ok ? load_ext(asm_q, size_r, sx_r) : rdata_q;
  assign ram_sel  = state == XFER;
  assign ram_we   = ram_sel && we_r;
  assign ram_addr = ram_sel ? base + ADDR_W'(cnt) : '0;
  assign ram_d    = ram_we ? wd[{cnt, 3'b000} +: 8] : 8'd0;

  // Loaded value is held in rdata_q so it survives until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      last    <= 2'd0;
      size_r  <= SZ_BYTE;
      we_r    <= 1'b0;
      sx_r    <= 1'b0;
      err_r   <= 1'b0;
      base    <= '0;
      wd      <= 32'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          we_r   <= we;
          size_r <= size;
          sx_r   <= sign_ext;
          base   <= addr;
          wd     <= wdata;
          last   <= n_m1[1:0];
          err_r  <= bad;
          cnt    <= 2'd0;
          state  <= bad ? DONE : XFER;
        end
        XFER: begin
          if (!we_r) asm_q <= asm_nx;
          cnt <= cnt + 2'd1;
          if (cnt == last) state <= DONE;
        end
        DONE: begin
          if (ld_ok) rdata_q <= load_ext(asm_q, size_r, sx_r);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb_mem_byte_sequencer: scoreboard bench with byte RAM and array reference model.
module tb_mem_byte_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, sign_ext = 1'b0, fill = 1'b1;
  logic [1:0]  size = 2'd0;
  logic [9:0]  addr = 10'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, done, err, ram_we, ram_sel;
  logic [31:0] rdata;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_d, ram_q;

  mem_byte_sequencer #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_sel(ram_sel), .ram_q(ram_q)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  logic [7:0]  mem [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] last_rd = 32'd0;
  exp_t        sbq [$];
  int          e = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];

  always @(posedge clk) begin
    e <= e + 1;
    if (fill) for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    else if (ram_we && ram_sel) mem[ram_addr] <= ram_d;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && !fill) begin
      if (ready) check("idle_ram_outputs", {12'd0, ram_we, ram_sel, ram_addr, ram_d}, 32'd0);
      if (ram_sel && sbq.size() > 0 && sbq[0].err) fail_now("ram_cycle_on_error");
      if (done) begin
        if (sbq.size() == 0) fail_now("unexpected_done");
        else begin
          x = sbq.pop_front();
          check("err", {31'd0, err}, {31'd0, x.err});
          check("rdata", rdata, x.rdata);
          check("done_cycle", 32'(e), 32'(x.at));
        end
      end
    end
  end

  // Model: the load value is built straight from the reference byte array.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [9:0] a, input logic [31:0] d);
    int n, guard;
    logic bad;
    logic [31:0] raw;
    exp_t x;
    guard = 0;
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    if (!ready) begin fail_now("ready_timeout"); return; end
    n = sz == 2'd2 ? 4 : sz == 2'd1 ? 2 : 1;
    bad = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    raw = 32'd0;
    if (!bad) for (int i = 0; i < n; i++) begin
      if (w) ref_mem[10'(a + i)] = d[8*i +: 8];
      else raw = raw | (32'(ref_mem[10'(a + i)]) << (8 * i));
    end
    if (!bad && !w)
      last_rd = n == 1 ? ((sx && raw >= 32'h80) ? raw | 32'hFFFFFF00 : raw) :
                n == 2 ? ((sx && raw >= 32'h8000) ? raw | 32'hFFFF0000 : raw) : raw;
    x.err = bad;
    x.rdata = last_rd;
    x.at = e + 1 + (bad ? 0 : n);
    sbq.push_back(x);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    guard = 0;
    do begin
      @(negedge clk);
      if (!done) begin
        we = 1'($urandom); size = 2'($urandom); addr = 10'($urandom); wdata = $urandom;
      end
      guard++;
    end while (!done && guard < 20);
    req = 1'b0;
    if (!done) fail_now("done_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    logic [9:0] a;
    int r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram", {12'd0, ram_we, ram_sel, ram_addr, ram_d}, 32'd0);
    fill = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    check("word_store_bytes", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 10'h010, 32'd0);
    check("word_load", rdata, 32'hDEADBEEF);
    issue(1'b1, 2'd1, 1'b0, 10'h020, 32'h55AA8034);
    issue(1'b0, 2'd1, 1'b1, 10'h020, 32'd0);
    check("half_load_sext", rdata, 32'hFFFF8034);
    issue(1'b0, 2'd1, 1'b0, 10'h020, 32'd0);
    check("half_load_zext", rdata, 32'h00008034);
    issue(1'b1, 2'd0, 1'b0, 10'h3FF, 32'h12345678);
    check("top_byte_store", {24'd0, mem[10'h3FF]}, 32'h78);
    issue(1'b0, 2'd2, 1'b0, 10'h006, 32'd0);
    check("misaligned_word_rdata", rdata, 32'h00008034);
    issue(1'b1, 2'd1, 1'b0, 10'h003, 32'hFFFFFFFF);
    issue(1'b0, 2'd3, 1'b1, 10'h100, 32'd0);
    check("reserved_err", {31'd0, err}, 32'd1);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      a = $urandom_range(0, 5) == 0 ? 10'($urandom) : 10'(10'h100 + $urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a = sz == 2'd2 ? a & 10'h3FC : sz == 2'd1 ? a & 10'h3FE : a;
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    // Reset lands in the XFER cycle for byte 2: only bytes 0 and 1 reach the RAM.
    while (!ready) @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 10'h040; wdata = 32'h11223344;
    ref_mem[10'h040] = 8'h44;
    ref_mem[10'h041] = 8'h33;
    repeat (3) @(posedge clk);
    #2;
    check("mid_xfer_sel", {30'd0, ram_sel, ram_we}, 32'd3);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("async_rst_ram", {30'd0, ram_sel, ram_we}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ready", {30'd0, ready, done}, 32'd2);
    end
    check("partial_store", {mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]},
          {ref_mem[10'h043], ref_mem[10'h042], 8'h33, 8'h44});

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) fail_now("scoreboard_not_drained");
    for (int i = 0; i < 1024; i++) check($sformatf("mem[%0h]", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
